// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequences the CPU's single memory port through MAR/MDR. Two requesters
//   (instruction fetch, data load/store) share the port. The winner's address,
//   rw and store data are latched in IDLE. The memory cycle then runs for a
//   fixed WAIT_CYC+1 cycles. In DONE the winner sees a one-cycle done pulse
//   with MDR on its rdata bus.
//
// Configuration macro:
//   MEM_ACC_RR_EN  defined   : round-robin arbitration. On a simultaneous
//                              request the requester that was not served last
//                              wins.
//                  undefined : fixed priority, data over fetch.
//
// Parameters:
//   ADDR_W    width of MAR / memory address
//   DATA_W    width of MDR / memory data
//   WAIT_CYC  extra memory cycles before read data is valid (0..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   fetch_req    fetch read request, level, held until fetch_done
//   fetch_addr   fetch address
//   fetch_done   1-cycle pulse, fetch_rdata valid
//   fetch_rdata  MDR contents
//   data_req     data request, level, held until data_done
//   data_rw      0 = read, 1 = write
//   data_addr    load/store address
//   data_wdata   store data
//   data_done    1-cycle pulse, access complete / data_rdata valid
//   data_rdata   MDR contents
//   mem_en       memory cycle active
//   mem_rw       0 = read, 1 = write (gated by mem_en)
//   mem_addr     MAR contents
//   mem_wdata    MDR contents
//   mem_rdata    memory read data, sampled on the last ACCESS cycle
//   busy         controller not in IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; arbitrates and latches MAR/rw/MDR
// ACCESS | memory cycle in progress, WAIT_CYC+1 cycles long
// DONE   | owner's done pulses for one cycle, rdata = MDR
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_done,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              data_req,
   input  logic              data_rw,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_done,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic       OWN_FETCH = 1'b0;
   localparam logic       OWN_DATA  = 1'b1;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic              owner_q, owner_d;
   logic              grant_data;

`ifdef MEM_ACC_RR_EN
   // On a tie, whoever was not served last goes next; a lone request always wins.
   always_comb begin
      grant_data = data_req;
      if (data_req && fetch_req) begin
         grant_data = (owner_q == OWN_FETCH);
      end
   end
`else
   assign grant_data = data_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         owner_q <= OWN_FETCH;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      owner_d = owner_q;
      case (state_q)
         ST_IDLE: begin
            if (data_req || fetch_req) begin
               cnt_d   = '0;
               state_d = ST_ACCESS;
               if (grant_data) begin
                  owner_d = OWN_DATA;
                  mar_d   = data_addr;
                  rw_d    = data_rw;
                  if (data_rw) begin
                     mdr_d = data_wdata;
                  end
               end else begin
                  owner_d = OWN_FETCH;
                  mar_d   = fetch_addr;
                  rw_d    = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WAIT_LAST) begin
               if (!rw_q) begin
                  mdr_d = mem_rdata;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode straight from state so an async reset drops mem_en at once.
   always_comb begin
      mem_en     = (state_q == ST_ACCESS);
      mem_rw     = (state_q == ST_ACCESS) && rw_q;
      fetch_done = (state_q == ST_DONE) && (owner_q == OWN_FETCH);
      data_done  = (state_q == ST_DONE) && (owner_q == OWN_DATA);
      busy       = (state_q != ST_IDLE);
   end

   assign mem_addr    = mar_q;
   assign mem_wdata   = mdr_q;
   assign fetch_rdata = mdr_q;
   assign data_rdata  = mdr_q;

endmodule
